// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-port (I/D) cache-to-memory arbiter.
// Holds the FSM state encoding and the line-request bundle.
package cache_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } line_req_t;

    function automatic line_req_t make_req(
        input logic [ADDR_W-1:0] addr,
        input logic              read,
        input logic              write,
        input logic [LINE_W-1:0] wdata
    );
        line_req_t r;
        r.addr  = addr;
        r.read  = read;
        r.write = write;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// and the D-cache; one transaction in flight at a time.
//
// Handshake: a cache holds read or write high until it sees a one-cycle resp;
// memory request (mem_read/mem_write) is held until a one-cycle mem_resp.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter bit PRIO_D = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [ADDR_W-1:0]    i_addr,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [LINE_W-1:0]    i_wdata,
    output logic [LINE_W-1:0]    i_rdata,
    output logic                 i_resp,

    input  logic [ADDR_W-1:0]    d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_W-1:0]    d_wdata,
    output logic [LINE_W-1:0]    d_rdata,
    output logic                 d_resp,

    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [LINE_W-1:0]    mem_wdata,
    input  logic [LINE_W-1:0]    mem_rdata,
    input  logic                 mem_resp,

    output arb_state_e           dbg_state,
    output logic                 dbg_last_gnt
);

    arb_state_e state_q, state_d;
    // 1 = D-port completed the last transaction, 0 = I-port.
    logic       last_gnt_q, last_gnt_d;

    line_req_t  i_req_s, d_req_s, mem_req_s;
    logic       i_req, d_req;
    logic       i_resp_c, d_resp_c;

    assign i_req_s = make_req(i_addr, i_read, i_write, i_wdata);
    assign d_req_s = make_req(d_addr, d_read, d_write, d_wdata);
    assign i_req   = i_read | i_write;
    assign d_req   = d_read | d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= !PRIO_D;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        mem_req_s  = '0;
        i_resp_c   = 1'b0;
        d_resp_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = last_gnt_q ? GNT_I : GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                mem_req_s = i_req_s;
                if (mem_resp) begin
                    i_resp_c   = 1'b1;
                    last_gnt_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            GNT_D: begin
                mem_req_s = d_req_s;
                if (mem_resp) begin
                    d_resp_c   = 1'b1;
                    last_gnt_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset squashes the control outputs in the same cycle, so an abandoned
    // transaction never leaks a request or a response.
    assign mem_addr     = mem_req_s.addr;
    assign mem_wdata    = mem_req_s.wdata;
    assign mem_read     = mem_req_s.read  & ~rst;
    assign mem_write    = mem_req_s.write & ~rst;
    assign i_resp       = i_resp_c & ~rst;
    assign d_resp       = d_resp_c & ~rst;
    assign i_rdata      = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign dbg_state    = state_q;
    assign dbg_last_gnt = last_gnt_q;

`ifndef SYNTHESIS
    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(i_read && i_write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));
    a_one_resp: assert property (@(posedge clk) !(i_resp && d_resp));
`endif

endmodule
